// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-compatible interrupt controller.
//   init_state_e : ICW initialization sequencer states
//   strobe_t     : one-cycle control-word strobes driven downstream
package pic_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ICW1_SEL = 4;  // d[4]=1 with A0=0 marks ICW1
  localparam int unsigned OCW3_SEL = 3;  // d[3] splits OCW2 (0) from OCW3 (1)
  localparam int unsigned SNGL     = 1;  // ICW1: single controller, skip ICW3
  localparam int unsigned IC4      = 0;  // ICW1: ICW4 follows

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } init_state_e;

  typedef struct packed {
    logic icw1;
    logic icw2;
    logic icw3;
    logic icw4;
    logic ocw1;
    logic ocw2;
    logic ocw3;
  } strobe_t;

endpackage

// File: rtl/pic_bus_control_logic_if.sv
// CPU-side bus of the interrupt controller.
//   master : CPU side, drives chip select, strobes, address and write data
//   slave  : controller side, returns read data and the read-cycle flag
interface pic_bus_control_logic_if;
  import pic_pkg::*;

  logic              CS_bar;
  logic              RD_bar;
  logic              WR_bar;
  logic              A0;
  logic [DATA_W-1:0] data_bus_buffer_in;
  logic [DATA_W-1:0] data_bus_buffer_out;
  logic              read;

  modport master (
    output CS_bar, RD_bar, WR_bar, A0, data_bus_buffer_in,
    input  data_bus_buffer_out, read
  );

  modport slave (
    input  CS_bar, RD_bar, WR_bar, A0, data_bus_buffer_in,
    output data_bus_buffer_out, read
  );

endinterface

// File: rtl/pic_bus_control_logic.sv
// Bus-interface front end of the interrupt controller: decodes CPU write
// cycles into one-cycle control-word strobes, sequences ICW1..ICW4 and
// returns the IMR shadow on reads.
//   clk, reset         : clock, asynchronous active-low reset
//   bus                : CPU bus (slave modport)
//   internal_bus       : last committed write byte
//   ICW_1..4, OCW_1..3 : one-cycle strobes, one per committed write at most
module pic_bus_control_logic
  import pic_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  pic_bus_control_logic_if.slave  bus,
  output logic [DATA_W-1:0]       internal_bus,
  output logic                    ICW_1,
  output logic                    ICW_2,
  output logic                    ICW_3,
  output logic                    ICW_4,
  output logic                    OCW_1,
  output logic                    OCW_2,
  output logic                    OCW_3
);

  logic              wr_act;
  logic              wr_act_q;
  logic              commit;
  logic              a0_q;
  logic [DATA_W-1:0] data_q;

  init_state_e       state_q,     state_d;
  logic              init_done_q, init_done_d;
  logic              sngl_q,      sngl_d;
  logic              ic4_q,       ic4_d;
  logic [DATA_W-1:0] imr_q,       imr_d;
  logic [DATA_W-1:0] bus_q,       bus_d;
  strobe_t           strobe_q,    strobe_d;

  // Access decode; simultaneous RD/WR low is treated as no access.
  assign wr_act   = !bus.CS_bar && !bus.WR_bar &&  bus.RD_bar;
  assign bus.read = !bus.CS_bar && !bus.RD_bar &&  bus.WR_bar;
  // A write takes effect on the first cycle after its active phase ends.
  assign commit   = wr_act_q && !wr_act;

  assign bus.data_bus_buffer_out = (bus.read && bus.A0) ? imr_q : DATA_W'(0);

  // Write capture: last byte/address seen while the write is active wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_act_q <= 1'b0;
      a0_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_act_q <= wr_act;
      if (wr_act) begin
        a0_q   <= bus.A0;
        data_q <= bus.data_bus_buffer_in;
      end
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= READY;
      init_done_q <= 1'b0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      imr_q       <= '0;
      bus_q       <= '0;
      strobe_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      imr_q       <= imr_d;
      bus_q       <= bus_d;
      strobe_q    <= strobe_d;
    end
  end

  // Control-word decode and ICW sequencing at write commit.
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    imr_d       = imr_q;
    bus_d       = bus_q;
    strobe_d    = '0;

    if (commit) begin
      bus_d = data_q;
      if (!a0_q && data_q[ICW1_SEL]) begin
        // ICW1 restarts initialization from any state.
        strobe_d.icw1 = 1'b1;
        sngl_d        = data_q[SNGL];
        ic4_d         = data_q[IC4];
        state_d       = WAIT_ICW2;
        init_done_d   = 1'b0;
      end else begin
        unique case (state_q)
          WAIT_ICW2: begin
            if (a0_q) begin
              strobe_d.icw2 = 1'b1;
              if (!sngl_q) begin
                state_d = WAIT_ICW3;
              end else if (ic4_q) begin
                state_d = WAIT_ICW4;
              end else begin
                state_d     = READY;
                init_done_d = 1'b1;
              end
            end
          end
          WAIT_ICW3: begin
            if (a0_q) begin
              strobe_d.icw3 = 1'b1;
              if (ic4_q) begin
                state_d = WAIT_ICW4;
              end else begin
                state_d     = READY;
                init_done_d = 1'b1;
              end
            end
          end
          WAIT_ICW4: begin
            if (a0_q) begin
              strobe_d.icw4 = 1'b1;
              state_d       = READY;
              init_done_d   = 1'b1;
            end
          end
          READY: begin
            if (init_done_q) begin
              if (a0_q) begin
                strobe_d.ocw1 = 1'b1;
                imr_d         = data_q;
              end else if (!data_q[OCW3_SEL]) begin
                strobe_d.ocw2 = 1'b1;
              end else begin
                strobe_d.ocw3 = 1'b1;
              end
            end
          end
          default: begin
            state_d = READY;
          end
        endcase
      end
    end
  end

  assign internal_bus = bus_q;
  assign ICW_1        = strobe_q.icw1;
  assign ICW_2        = strobe_q.icw2;
  assign ICW_3        = strobe_q.icw3;
  assign ICW_4        = strobe_q.icw4;
  assign OCW_1        = strobe_q.ocw1;
  assign OCW_2        = strobe_q.ocw2;
  assign OCW_3        = strobe_q.ocw3;

endmodule

// File: tb/tb_pic_bus_control_logic.sv
// Self-checking bench for pic_bus_control_logic: directed vector table,
// hand-written reset/ignored-access sequences, then random bus traffic
// against a queue-based model of the initialization protocol.
module tb_pic_bus_control_logic;

  logic       clk;
  logic       reset;
  logic [7:0] internal_bus;
  logic       ICW_1, ICW_2, ICW_3, ICW_4, OCW_1, OCW_2, OCW_3;
  logic [6:0] strobes;

  int checks = 0;
  int errors = 0;

  pic_bus_control_logic_if bus_if ();

  pic_bus_control_logic dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if.slave),
    .internal_bus (internal_bus),
    .ICW_1        (ICW_1),
    .ICW_2        (ICW_2),
    .ICW_3        (ICW_3),
    .ICW_4        (ICW_4),
    .OCW_1        (OCW_1),
    .OCW_2        (OCW_2),
    .OCW_3        (OCW_3)
  );

  assign strobes = {ICW_1, ICW_2, ICW_3, ICW_4, OCW_1, OCW_2, OCW_3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: codes 1..4 = ICW1..ICW4, 5..7 = OCW1..OCW3, 0 = none.
  int         pending[$];
  bit         m_init_done;
  logic [7:0] m_imr;
  logic [7:0] m_bus;

  function automatic logic [6:0] code_vec(input int code);
    logic [6:0] v;
    v = '0;
    if (code >= 1 && code <= 7) v[7-code] = 1'b1;
    return v;
  endfunction

  function automatic void model_reset();
    pending.delete();
    m_init_done = 1'b0;
    m_imr       = 8'h00;
    m_bus       = 8'h00;
  endfunction

  function automatic int model_write(input logic a0, input logic [7:0] d);
    int code;
    code  = 0;
    m_bus = d;
    if (!a0 && d[4]) begin
      code = 1;
      pending.delete();
      pending.push_back(2);
      if (!d[1]) pending.push_back(3);
      if (d[0])  pending.push_back(4);
      m_init_done = 1'b0;
    end else if (pending.size() > 0) begin
      if (a0) begin
        code = pending.pop_front();
        if (pending.size() == 0) m_init_done = 1'b1;
      end
    end else if (m_init_done) begin
      if (a0) begin
        code  = 5;
        m_imr = d;
      end else begin
        code = d[3] ? 7 : 6;
      end
    end
    return code;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.CS_bar = 1'b1;
    bus_if.RD_bar = 1'b1;
    bus_if.WR_bar = 1'b1;
  endtask

  // Full write cycle; strobes checked on the commit cycle and the one after.
  task automatic do_write(input logic a0, input logic [7:0] d, input int hold,
                          input int exp_code, input string name);
    bus_if.CS_bar = 1'b0;
    bus_if.RD_bar = 1'b1;
    bus_if.WR_bar = 1'b0;
    bus_if.A0     = a0;
    bus_if.data_bus_buffer_in = d;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, "_hold_strobes"}, 32'(strobes), 32'h0);
    end
    idle();
    bus_if.A0 = 1'($urandom);
    bus_if.data_bus_buffer_in = 8'($urandom);
    tick();
    chk({name, "_strobe"}, 32'(strobes), 32'(code_vec(exp_code)));
    chk({name, "_bus"}, 32'(internal_bus), 32'(d));
    tick();
    chk({name, "_strobe_clear"}, 32'(strobes), 32'h0);
  endtask

  task automatic do_read(input logic a0, input logic [7:0] exp, input string name);
    bus_if.CS_bar = 1'b0;
    bus_if.RD_bar = 1'b0;
    bus_if.WR_bar = 1'b1;
    bus_if.A0     = a0;
    #1;
    chk({name, "_read"}, 32'(bus_if.read), 32'h1);
    chk({name, "_dout"}, 32'(bus_if.data_bus_buffer_out), 32'(exp));
    tick();
    idle();
    #1;
    chk({name, "_read_end"}, 32'(bus_if.read), 32'h0);
    tick();
    chk({name, "_no_strobe"}, 32'(strobes), 32'h0);
  endtask

  // Asynchronous reset pulse placed mid-cycle.
  task automatic do_reset(input string name);
    #2;
    reset = 1'b0;
    #1;
    chk({name, "_strobes"}, 32'(strobes), 32'h0);
    chk({name, "_bus"}, 32'(internal_bus), 32'h0);
    model_reset();
    tick();
    reset = 1'b1;
    tick();
  endtask

  typedef struct {
    logic       a0;
    logic [7:0] d;
    int         code;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int unused_code;
    idle();
    bus_if.A0 = 1'b0;
    bus_if.data_bus_buffer_in = 8'h00;
    reset = 1'b1;
    model_reset();

    // Reset held with a conflicting RD/WR access on the bus.
    #1;
    reset = 1'b0;
    bus_if.CS_bar = 1'b0;
    bus_if.RD_bar = 1'b0;
    bus_if.WR_bar = 1'b0;
    #1;
    chk("rst_strobes", 32'(strobes), 32'h0);
    chk("rst_read", 32'(bus_if.read), 32'h0);
    chk("rst_dout", 32'(bus_if.data_bus_buffer_out), 32'h0);
    chk("rst_bus", 32'(internal_bus), 32'h0);
    tick();
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();

    vecs = '{
      '{1'b0, 8'h13, 1}, '{1'b1, 8'h20, 2}, '{1'b1, 8'h01, 4},
      '{1'b0, 8'h11, 1}, '{1'b1, 8'h20, 2}, '{1'b1, 8'h04, 3}, '{1'b1, 8'h01, 4},
      '{1'b1, 8'hAA, 5}, '{1'b0, 8'h20, 6}, '{1'b0, 8'h0A, 7},
      '{1'b0, 8'h18, 1}, '{1'b0, 8'h08, 0}, '{1'b1, 8'h30, 2}, '{1'b1, 8'h05, 3},
      '{1'b1, 8'h55, 5}, '{1'b0, 8'h1A, 1}, '{1'b1, 8'h40, 2}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      unused_code = model_write(vecs[i].a0, vecs[i].d);
      do_write(vecs[i].a0, vecs[i].d, 1 + (i % 3), vecs[i].code, $sformatf("vec%0d", i));
      if (i == 7) do_read(1'b1, 8'hAA, "imr_rb");
    end
    // Sequence above ended in READY after ICW1(SNGL=1,IC4=0)+ICW2; imr=55.
    do_read(1'b1, 8'h55, "imr_rb2");
    do_read(1'b0, 8'h00, "a0_low_rb");

    // Before init: OCW1 ignored, readback zero.
    do_reset("rst_pre");
    do_write(1'b1, 8'hAA, 1, 0, "pre_ocw1");
    do_read(1'b1, 8'h00, "pre_rb");

    // CS_bar high write must be invisible.
    bus_if.CS_bar = 1'b1;
    bus_if.WR_bar = 1'b0;
    bus_if.A0 = 1'b0;
    bus_if.data_bus_buffer_in = 8'h13;
    tick();
    idle();
    tick();
    chk("cs_hi_strobes", 32'(strobes), 32'h0);
    chk("cs_hi_bus", 32'(internal_bus), 32'hAA);

    // Reset after ICW2 returns to READY; following A0=1 write gives no strobe.
    unused_code = model_write(1'b0, 8'h11);
    do_write(1'b0, 8'h11, 1, 1, "mid_icw1");
    unused_code = model_write(1'b1, 8'h20);
    do_write(1'b1, 8'h20, 1, 2, "mid_icw2");
    do_reset("rst_mid");
    do_write(1'b1, 8'h04, 1, 0, "mid_after_rst");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int         r;
      logic       a0;
      logic [7:0] d;
      int         code;
      r  = int'($urandom_range(0, 19));
      a0 = 1'($urandom);
      d  = 8'($urandom);
      if (r < 3) begin
        a0   = 1'b0;
        d[4] = 1'b1;
      end
      if (r < 12) begin
        code = model_write(a0, d);
        do_write(a0, d, int'($urandom_range(1, 3)), code, $sformatf("rnd%0d", n));
      end else if (r < 15) begin
        do_read(a0, a0 ? m_imr : 8'h00, $sformatf("rrd%0d", n));
      end else if (r < 17) begin
        bus_if.CS_bar = 1'b1;
        bus_if.WR_bar = 1'b0;
        bus_if.A0 = a0;
        bus_if.data_bus_buffer_in = d;
        tick();
        idle();
        tick();
        chk($sformatf("rcs%0d_strobes", n), 32'(strobes), 32'h0);
        chk($sformatf("rcs%0d_bus", n), 32'(internal_bus), 32'(m_bus));
      end else if (r < 19) begin
        bus_if.CS_bar = 1'b0;
        bus_if.RD_bar = 1'b0;
        bus_if.WR_bar = 1'b0;
        bus_if.A0 = a0;
        bus_if.data_bus_buffer_in = d;
        #1;
        chk($sformatf("rcf%0d_read", n), 32'(bus_if.read), 32'h0);
        chk($sformatf("rcf%0d_dout", n), 32'(bus_if.data_bus_buffer_out), 32'h0);
        tick();
        idle();
        tick();
        chk($sformatf("rcf%0d_strobes", n), 32'(strobes), 32'h0);
      end else begin
        do_reset($sformatf("rrst%0d", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
